// File: rtl/wb_accel_job_master_pkg.sv
// Shared definitions for the accelerator job master: register map, status and error codes,
// FSM encodings and the SRAM word address helper.
package wb_accel_job_master_pkg;

    localparam logic [31:0] OFS_OP       = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS   = 32'h0000_0004;
    localparam logic [31:0] OFS_SRAM     = 32'h0000_0008;

    localparam logic [31:0] STATUS_START = 32'hFFFF_FFFF;
    localparam logic [31:0] STATUS_IDLE  = 32'h0000_0000;

    localparam logic [1:0]  ERR_OK          = 2'd0;
    localparam logic [1:0]  ERR_ACK_TIMEOUT = 2'd1;
    localparam logic [1:0]  ERR_POLL_LIMIT  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_OPND   = 4'd1,
        S_WR_OP     = 4'd2,
        S_WR_GO     = 4'd3,
        S_POLL      = 4'd4,
        S_POLL_WAIT = 4'd5,
        S_RD_RES    = 4'd6,
        S_FIN       = 4'd7,
        S_ABORT     = 4'd8
    } job_state_e;

    typedef enum logic [1:0] {
        X_IDLE   = 2'd0,
        X_ACTIVE = 2'd1,
        X_GAP    = 2'd2
    } xfer_state_e;

    // The word index wraps in 8 bits; the byte address wraps in 32 bits.
    function automatic logic [31:0] sram_adr(input logic [31:0] base, input logic [7:0] idx);
        return base + OFS_SRAM + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic single transfer per request: drives cyc/stb/sel, captures read data on ack,
// forces an idle cycle after every transfer and aborts if ack does not arrive in time.
module wb_single_xfer
    import wb_accel_job_master_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    xfer_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          act_q, act_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    // Transfer sequencing: request accepted only from X_IDLE, so X_GAP guarantees a dead bus cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        act_d     = act_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            X_IDLE: begin
                if (req) begin
                    state_d = X_ACTIVE;
                    act_d   = 1'b1;
                    we_d    = we;
                    sel_d   = 4'hF;
                    adr_d   = adr;
                    dat_d   = wdata;
                    timer_d = {TW{1'b0}};
                end else begin
                    state_d = X_IDLE;
                end
            end
            X_ACTIVE: begin
                // A late ack in the final timeout cycle still wins.
                if (ack_i) begin
                    state_d = X_GAP;
                    act_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = dat_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d   = X_GAP;
                    act_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'h0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            X_GAP: begin
                state_d = X_IDLE;
            end
            default: begin
                state_d = X_IDLE;
                act_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = 4'h0;
            end
        endcase
    end

    // Transfer state and bus output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= X_IDLE;
            timer_q   <= {TW{1'b0}};
            act_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0000_0000;
            dat_q     <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            act_q     <= act_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign cyc_o   = act_q;
    assign stb_o   = act_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/wb_accel_job_master.sv
// Job-level master for the AI accelerator slave: load operands, program and start the op,
// poll status, then stream results out through a one-word buffer.
module wb_accel_job_master
    import wb_accel_job_master_pkg::*;
#(
    parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = 64,
    parameter int          POLL_GAP    = 8,
    parameter int          MAX_POLLS   = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        job_start,
    input  logic [31:0] job_op,
    input  logic [7:0]  job_n_in,
    input  logic [7:0]  job_out_base,
    input  logic [7:0]  job_n_out,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    job_state_e    state_q, state_d;
    logic [31:0]   op_q, op_d;
    logic [7:0]    n_in_q, n_in_d, out_base_q, out_base_d, n_out_q, n_out_d;
    logic [7:0]    idx_q, idx_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]   opnd_q, opnd_d;
    logic          opnd_full_q, opnd_full_d;
    logic [1:0]    err_q, err_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;

    logic          x_req_s, x_we_s, x_done_s, x_timeout_s;
    logic [31:0]   x_adr_s, x_wdata_s, x_rdata_s;
    logic [7:0]    idx_inc_s;
    logic [PW-1:0] poll_inc_s;

    wb_single_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .req     (x_req_s),
        .we      (x_we_s),
        .adr     (x_adr_s),
        .wdata   (x_wdata_s),
        .done    (x_done_s),
        .rdata   (x_rdata_s),
        .timeout (x_timeout_s),
        .cyc_o   (wbm_cyc_o),
        .stb_o   (wbm_stb_o),
        .we_o    (wbm_we_o),
        .sel_o   (wbm_sel_o),
        .adr_o   (wbm_adr_o),
        .dat_o   (wbm_dat_o),
        .ack_i   (wbm_ack_i),
        .dat_i   (wbm_dat_i)
    );

    // Job FSM: next state, counters, stream buffers and transfer requests.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        n_in_d      = n_in_q;
        out_base_d  = out_base_q;
        n_out_d     = n_out_q;
        idx_d       = idx_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        opnd_d      = opnd_q;
        opnd_full_d = opnd_full_q;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        x_req_s     = 1'b0;
        x_we_s      = 1'b0;
        x_adr_s     = ADDR_OFFSET;
        x_wdata_s   = 32'h0000_0000;
        idx_inc_s   = idx_q + 8'd1;
        poll_inc_s  = poll_cnt_q + {{(PW-1){1'b0}}, 1'b1};
        case (state_q)
            S_IDLE, S_FIN, S_ABORT: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                if (job_start) begin
                    op_d        = job_op;
                    n_in_d      = job_n_in;
                    out_base_d  = job_out_base;
                    n_out_d     = job_n_out;
                    idx_d       = 8'd0;
                    opnd_full_d = 1'b0;
                    err_d       = ERR_OK;
                    busy_d      = 1'b1;
                    state_d     = (job_n_in == 8'd0) ? S_WR_OP : S_WR_OPND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_OPND: begin
                if (!opnd_full_q) begin
                    if (in_ready_q && in_valid) begin
                        opnd_d      = in_data;
                        opnd_full_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end else begin
                    x_req_s   = 1'b1;
                    x_we_s    = 1'b1;
                    x_adr_s   = sram_adr(ADDR_OFFSET, idx_q);
                    x_wdata_s = opnd_q;
                    if (x_done_s) begin
                        opnd_full_d = 1'b0;
                        if (idx_inc_s == n_in_q) begin
                            idx_d   = 8'd0;
                            state_d = S_WR_OP;
                        end else begin
                            idx_d = idx_inc_s;
                        end
                    end else begin
                        opnd_full_d = 1'b1;
                    end
                end
            end
            S_WR_OP: begin
                x_req_s   = 1'b1;
                x_we_s    = 1'b1;
                x_adr_s   = ADDR_OFFSET + OFS_OP;
                x_wdata_s = op_q;
                if (x_done_s) begin
                    state_d = S_WR_GO;
                end else begin
                    state_d = S_WR_OP;
                end
            end
            S_WR_GO: begin
                x_req_s   = 1'b1;
                x_we_s    = 1'b1;
                x_adr_s   = ADDR_OFFSET + OFS_STATUS;
                x_wdata_s = STATUS_START;
                if (x_done_s) begin
                    poll_cnt_d = {PW{1'b0}};
                    state_d    = S_POLL;
                end else begin
                    state_d = S_WR_GO;
                end
            end
            S_POLL: begin
                x_req_s = 1'b1;
                x_adr_s = ADDR_OFFSET + OFS_STATUS;
                if (x_done_s) begin
                    poll_cnt_d = poll_inc_s;
                    if (x_rdata_s == STATUS_IDLE) begin
                        idx_d = 8'd0;
                        if (n_out_q == 8'd0) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_RD_RES;
                        end
                    end else if (poll_inc_s == PW'(MAX_POLLS)) begin
                        state_d = S_ABORT;
                        err_d   = ERR_POLL_LIMIT;
                        busy_d  = 1'b0;
                    end else begin
                        gap_cnt_d = {GW{1'b0}};
                        state_d   = S_POLL_WAIT;
                    end
                end else begin
                    state_d = S_POLL;
                end
            end
            S_POLL_WAIT: begin
                if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
                    state_d = S_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            S_RD_RES: begin
                // Next read waits until the buffered word has been taken.
                if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q == n_out_q) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_RD_RES;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else begin
                    x_req_s = 1'b1;
                    x_adr_s = sram_adr(ADDR_OFFSET, out_base_q + idx_q);
                    if (x_done_s) begin
                        out_valid_d = 1'b1;
                        out_data_d  = x_rdata_s;
                        idx_d       = idx_inc_s;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (x_timeout_s) begin
            state_d     = S_ABORT;
            err_d       = ERR_ACK_TIMEOUT;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            opnd_full_d = 1'b0;
        end else begin
            err_d = err_d;
        end
    end

    // Job state and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= 32'h0000_0000;
            n_in_q      <= 8'd0;
            out_base_q  <= 8'd0;
            n_out_q     <= 8'd0;
            idx_q       <= 8'd0;
            poll_cnt_q  <= {PW{1'b0}};
            gap_cnt_q   <= {GW{1'b0}};
            opnd_q      <= 32'h0000_0000;
            opnd_full_q <= 1'b0;
            err_q       <= ERR_OK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            n_in_q      <= n_in_d;
            out_base_q  <= out_base_d;
            n_out_q     <= n_out_d;
            idx_q       <= idx_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            opnd_q      <= opnd_d;
            opnd_full_q <= opnd_full_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_accel_job_master.sv
// Directed bench for wb_accel_job_master with a behavioural accelerator slave
// (registered ack, same-cycle ack or no ack) and a bus monitor.
module tb_wb_accel_job_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        job_start = 1'b0;
    logic [31:0] job_op = 32'h0;
    logic [7:0]  job_n_in = 8'd0, job_out_base = 8'd0, job_n_out = 8'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int n_err = 0;
    int n_chk = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_accel_job_master #(.ADDR_OFFSET(BASE), .ACK_TIMEOUT(64), .POLL_GAP(8), .MAX_POLLS(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .job_start(job_start), .job_op(job_op),
        .job_n_in(job_n_in), .job_out_base(job_out_base), .job_n_out(job_n_out),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    // Slave model: 0 = registered ack, 1 = same-cycle ack, 2 = never ack
    int          slave_mode = 0;
    int          busy_polls = 0;
    logic        ack_r = 1'b0;
    logic [31:0] mem [0:255];
    int          polls_done = 0, status_reads = 0, sram_reads = 0, done_cnt = 0, bb_viol = 0, log_n = 0;
    logic [31:0] log_adr [0:15];
    logic [31:0] log_dat [0:15];
    logic        prev_acked = 1'b0;
    logic        clr_stats = 1'b0, pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_val = 32'h0;
    logic [31:0] off_s;
    logic [7:0]  sidx_s;

    assign off_s     = wbm_adr_o - BASE - 32'd8;
    assign sidx_s    = off_s[9:2];
    assign wbm_ack_i = (slave_mode == 1) ? (wbm_cyc_o & wbm_stb_o) : ack_r;

    always_comb begin
        if (wbm_adr_o == BASE + 32'd4) wbm_dat_i = (polls_done < busy_polls) ? 32'hFFFF_FFFF : 32'h0;
        else if (wbm_adr_o >= BASE + 32'd8) wbm_dat_i = mem[sidx_s];
        else wbm_dat_i = 32'h0;
    end

    always @(posedge wb_clk_i) begin
        ack_r <= (slave_mode == 0) && wbm_cyc_o && wbm_stb_o && !ack_r;
        if (pre_en) mem[pre_idx] <= pre_val;
        if (clr_stats) begin
            status_reads <= 0; sram_reads <= 0; done_cnt <= 0; bb_viol <= 0; log_n <= 0; prev_acked <= 1'b0;
        end else begin
            if (wbm_stb_o && prev_acked) bb_viol <= bb_viol + 1;
            prev_acked <= wbm_cyc_o && wbm_stb_o && wbm_ack_i;
            if (done) done_cnt <= done_cnt + 1;
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                if (wbm_we_o) begin
                    if (log_n < 16) begin
                        log_adr[log_n[3:0]] <= wbm_adr_o;
                        log_dat[log_n[3:0]] <= wbm_dat_o;
                    end
                    log_n <= log_n + 1;
                    if (wbm_adr_o >= BASE + 32'd8) mem[sidx_s] <= wbm_dat_o;
                    if (wbm_adr_o == BASE + 32'd4 && wbm_dat_o == 32'hFFFF_FFFF) polls_done <= 0;
                end else if (wbm_adr_o == BASE + 32'd4) begin
                    status_reads <= status_reads + 1;
                    polls_done   <= polls_done + 1;
                end else if (wbm_adr_o >= BASE + 32'd8) begin
                    sram_reads <= sram_reads + 1;
                end
            end
        end
    end

    task automatic clear_stats();
        @(negedge wb_clk_i); clr_stats = 1'b1;
        @(negedge wb_clk_i); clr_stats = 1'b0;
    endtask

    task automatic preset(input logic [7:0] idx, input logic [31:0] val);
        @(negedge wb_clk_i); pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge wb_clk_i); pre_en = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] op, input logic [7:0] n_in, input logic [7:0] base,
                             input logic [7:0] n_out);
        @(negedge wb_clk_i);
        job_op = op; job_n_in = n_in; job_out_base = base; job_n_out = n_out; job_start = 1'b1;
        @(negedge wb_clk_i);
        job_start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        @(negedge wb_clk_i); in_valid = 1'b1; in_data = w;
        for (int c = 0; c < 100; c++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge wb_clk_i);
        end
        @(posedge wb_clk_i); #1; in_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] d, output bit ok);
        ok = 1'b0; d = 32'h0;
        @(negedge wb_clk_i); out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (out_valid) begin ok = 1'b1; d = out_data; break; end
            @(negedge wb_clk_i);
        end
        @(posedge wb_clk_i); #1; out_ready = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge wb_clk_i);
            if (done) begin seen = 1'b1; break; end
        end
    endtask

    task automatic wait_stb(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (wbm_stb_o) begin seen = 1'b1; break; end
            @(negedge wb_clk_i);
        end
    endtask

    task automatic wait_out_valid(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge wb_clk_i);
        end
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        n_chk++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_bus: cyc=%b stb=%b want 0 0", wbm_cyc_o, wbm_stb_o); end
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: busy=%b done=%b want 0 0", busy, done); end
        n_chk++; if (err !== 2'd0) begin n_err++; $display("FAIL reset_err: got %0d want 0", err); end
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL reset_stream: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready); end
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
    endtask

    task automatic test_basic_job();
        logic [31:0] exp_a [0:4];
        logic [31:0] exp_d [0:4];
        logic [31:0] d;
        bit ok, ok_all, seen;
        exp_a[0] = BASE + 32'h8;  exp_a[1] = BASE + 32'hC; exp_a[2] = BASE + 32'h10;
        exp_a[3] = BASE;          exp_a[4] = BASE + 32'h4;
        exp_d[0] = 32'd5; exp_d[1] = 32'd6; exp_d[2] = 32'd7; exp_d[3] = 32'd1; exp_d[4] = 32'hFFFF_FFFF;
        slave_mode = 0; busy_polls = 2;
        preset(8'd3, 32'd56);
        clear_stats();
        start_job(32'd1, 8'd3, 8'd3, 8'd1);
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        ok_all = 1'b1;
        feed(32'd5, ok); ok_all &= ok;
        feed(32'd6, ok); ok_all &= ok;
        feed(32'd7, ok); ok_all &= ok;
        n_chk++; if (ok_all !== 1'b1) begin n_err++; $display("FAIL basic_feed: accepted=%b want 1", ok_all); end
        collect(d, ok);
        n_chk++; if (!ok || d !== 32'd56) begin n_err++; $display("FAIL basic_out: got %0d (valid=%b) want 56", d, ok); end
        wait_done(seen);
        n_chk++; if (seen !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", seen); end
        n_chk++; if (log_n != 5) begin n_err++; $display("FAIL basic_nwrites: got %0d want 5", log_n); end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (log_adr[i] !== exp_a[i] || log_dat[i] !== exp_d[i]) begin
                n_err++; $display("FAIL basic_write%0d: got %h=%h want %h=%h", i, log_adr[i], log_dat[i], exp_a[i], exp_d[i]);
            end
        end
        n_chk++; if (status_reads != 3) begin n_err++; $display("FAIL basic_polls: got %0d want 3", status_reads); end
        n_chk++; if (err !== 2'd0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_end: err=%0d busy=%b want 0 0", err, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1;
        bit ok0, ok1, ok2, ok3, seen;
        slave_mode = 1; busy_polls = 1;
        clear_stats();
        start_job(32'd2, 8'd2, 8'd0, 8'd2);
        feed(32'd9, ok0);
        feed(32'd10, ok1);
        collect(d0, ok2);
        collect(d1, ok3);
        wait_done(seen);
        n_chk++; if (!(ok0 && ok1 && ok2 && ok3) || d0 !== 32'd9 || d1 !== 32'd10) begin n_err++; $display("FAIL b2b_data: got %0d,%0d want 9,10", d0, d1); end
        n_chk++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", seen); end
        n_chk++; if (bb_viol != 0) begin n_err++; $display("FAIL b2b_idle_gap: stb after ack %0d times want 0", bb_viol); end
        n_chk++; if (log_n != 4) begin n_err++; $display("FAIL b2b_nwrites: got %0d want 4", log_n); end
        slave_mode = 0;
    endtask

    task automatic test_ack_timeout();
        bit ok, seen;
        int cnt;
        slave_mode = 2;
        clear_stats();
        start_job(32'd1, 8'd1, 8'd0, 8'd1);
        feed(32'hDEAD, ok);
        wait_stb(seen);
        n_chk++; if (!(ok && seen)) begin n_err++; $display("FAIL tmo_stb: stb seen=%b want 1", seen); end
        cnt = 0;
        while (wbm_cyc_o && cnt < 200) begin cnt++; @(negedge wb_clk_i); end
        n_chk++; if (cnt != 64) begin n_err++; $display("FAIL tmo_cycles: cyc high %0d cycles want 64", cnt); end
        repeat (3) @(negedge wb_clk_i);
        n_chk++; if (err !== 2'd1 || busy !== 1'b0) begin n_err++; $display("FAIL tmo_err: err=%0d busy=%b want 1 0", err, busy); end
        n_chk++; if (done_cnt != 0) begin n_err++; $display("FAIL tmo_nodone: done pulses %0d want 0", done_cnt); end
        slave_mode = 0;
    endtask

    task automatic test_poll_limit();
        bit idle;
        slave_mode = 0; busy_polls = 1000;
        clear_stats();
        start_job(32'd1, 8'd0, 8'd0, 8'd1);
        idle = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge wb_clk_i);
            if (!busy) begin idle = 1'b1; break; end
        end
        n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL poll_end: busy still %b want 0", busy); end
        n_chk++; if (status_reads != 4) begin n_err++; $display("FAIL poll_reads: got %0d want 4", status_reads); end
        n_chk++; if (err !== 2'd2 || done_cnt != 0) begin n_err++; $display("FAIL poll_err: err=%0d done=%0d want 2 0", err, done_cnt); end
    endtask

    task automatic test_out_backpressure();
        logic [31:0] d0, d1;
        bit ok0, ok1, seen, vseen;
        slave_mode = 0; busy_polls = 0;
        preset(8'd10, 32'hAAAA_0001);
        preset(8'd11, 32'hBBBB_0002);
        clear_stats();
        start_job(32'd3, 8'd0, 8'd10, 8'd2);
        n_chk++; if (err !== 2'd0) begin n_err++; $display("FAIL bp_err_clear: got %0d want 0", err); end
        wait_out_valid(vseen);
        repeat (20) @(negedge wb_clk_i);
        n_chk++; if (!vseen || out_valid !== 1'b1 || sram_reads != 1) begin n_err++; $display("FAIL bp_hold: valid=%b reads=%0d want 1 1", out_valid, sram_reads); end
        collect(d0, ok0);
        collect(d1, ok1);
        wait_done(seen);
        n_chk++; if (!(ok0 && ok1) || d0 !== 32'hAAAA_0001 || d1 !== 32'hBBBB_0002) begin n_err++; $display("FAIL bp_data: got %h,%h want aaaa0001,bbbb0002", d0, d1); end
        n_chk++; if (seen !== 1'b1 || sram_reads != 2) begin n_err++; $display("FAIL bp_done: done=%b reads=%0d want 1 2", seen, sram_reads); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok0, ok1, ok2, seen;
        slave_mode = 2;
        start_job(32'd1, 8'd0, 8'd0, 8'd0);
        wait_stb(seen);
        wb_rst_ni = 1'b0;
        @(negedge wb_clk_i);
        n_chk++; if (!seen || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_bus: cyc=%b stb=%b busy=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, busy); end
        wb_rst_ni = 1'b1;
        slave_mode = 0; busy_polls = 0;
        preset(8'd20, 32'h77);
        start_job(32'd1, 8'd0, 8'd20, 8'd1);
        wait_out_valid(seen);
        wb_rst_ni = 1'b0;
        @(negedge wb_clk_i);
        n_chk++; if (!seen || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out: out_valid=%b want 0", out_valid); end
        wb_rst_ni = 1'b1;
        busy_polls = 1;
        clear_stats();
        start_job(32'd2, 8'd2, 8'd0, 8'd1);
        feed(32'h11, ok0);
        in_valid = 1'b0;
        repeat (12) @(negedge wb_clk_i);
        n_chk++; if (wbm_cyc_o !== 1'b0 || in_ready !== 1'b1 || log_n != 1) begin n_err++; $display("FAIL gap_idle: cyc=%b in_ready=%b writes=%0d want 0 1 1", wbm_cyc_o, in_ready, log_n); end
        feed(32'h22, ok1);
        collect(d, ok2);
        wait_done(seen);
        n_chk++; if (!(ok0 && ok1 && ok2) || d !== 32'h11 || mem[1] !== 32'h22) begin n_err++; $display("FAIL rerun_data: out=%h mem1=%h want 11 22", d, mem[1]); end
        n_chk++; if (seen !== 1'b1 || err !== 2'd0 || log_n != 4) begin n_err++; $display("FAIL rerun_done: done=%b err=%0d writes=%0d want 1 0 4", seen, err, log_n); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_job();
        test_back_to_back();
        test_ack_timeout();
        test_poll_limit();
        test_out_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
